// File: rtl/rename_pkg.sv
// Shared defaults, commit-queue entry and FSM state types for the rename front-end sequencer.
package rename_pkg;

   localparam int unsigned RN_ARCH_W = 4;
   localparam int unsigned RN_PHYS_W = 4;
   localparam int unsigned RN_QDEPTH = 8;

   typedef struct packed {
      logic                 has_dst;
      logic [RN_PHYS_W-1:0] old;
   } commit_entry_t;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      FREE_STALL = 2'd1,
      Q_STALL    = 2'd2,
      OUT_STALL  = 2'd3
   } rseq_state_t;

   // Highest-priority stall cause this cycle, RUN when nothing is blocking.
   function automatic rseq_state_t rseq_stall_cause(input logic free_stall,
                                                    input logic q_stall,
                                                    input logic out_stall);
      rseq_state_t cause;
      cause = RUN;
      if (free_stall) begin
         cause = FREE_STALL;
      end else if (q_stall) begin
         cause = Q_STALL;
      end else if (out_stall) begin
         cause = OUT_STALL;
      end
      return cause;
   endfunction

endpackage

// File: rtl/rename_commit_fifo.sv
// In-order queue of displaced physical mappings awaiting commit.
// A pop at full frees the slot so a same-cycle push still lands.
module rename_commit_fifo
   import rename_pkg::*;
#(
   parameter int unsigned DEPTH = RN_QDEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  commit_entry_t i_data,
   input  logic          i_pop,
   output commit_entry_t o_head_c,
   output logic          o_full_c,
   output logic          o_empty_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   commit_entry_t    r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_empty_c = (r_count == '0);
   assign o_full_c  = (r_count == CNT_W'(DEPTH));
   assign o_head_c  = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty_c;
   assign w_do_push = i_push & (~o_full_c | w_do_pop);

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

endmodule

// File: rtl/rename_sequencer.sv
// Rename front-end sequencer: drives the renamer for each accepted op, registers the renamed op
// for dispatch and retires displaced physical registers one per in-order commit.
module rename_sequencer
   import rename_pkg::*;
#(
   parameter int unsigned ARCH_W = RN_ARCH_W,
   parameter int unsigned PHYS_W = RN_PHYS_W,
   parameter int unsigned QDEPTH = RN_QDEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ARCH_W-1:0]   in_src1,
   input  logic [ARCH_W-1:0]   in_src2,
   input  logic [1:0]          in_src_ena,
   input  logic [ARCH_W-1:0]   in_dst,
   input  logic                in_dst_ena,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PHYS_W-1:0]   out_psrc1,
   output logic [PHYS_W-1:0]   out_psrc2,
   output logic [PHYS_W-1:0]   out_pdst,
   output logic [1:0]          out_src_ena,
   output logic                out_dst_ena,
   input  logic                commit_valid,
   output logic                commit_err,
   output logic [1:0]          state_o,
   output logic [ARCH_W-1:0]   rn_read1,
   output logic [ARCH_W-1:0]   rn_read2,
   output logic [1:0]          rn_read_ena,
   output logic [ARCH_W-1:0]   rn_write,
   output logic                rn_write_ena,
   output logic                rn_ena,
   output logic [PHYS_W-1:0]   rn_retire,
   output logic                rn_retire_ena,
   input  logic [PHYS_W-1:0]   rn_read1_phys,
   input  logic [PHYS_W-1:0]   rn_read2_phys,
   input  logic [2*PHYS_W-1:0] rn_wbs,
   input  logic                rn_full
);

   commit_entry_t     w_push_entry;
   commit_entry_t     w_head;
   logic              w_q_full;
   logic              w_q_empty;
   logic              w_pop;
   logic              w_slot_free;
   logic              w_accept;
   logic              w_free_stall;
   logic              w_q_stall;
   logic              w_out_stall;
   logic [PHYS_W-1:0] w_wbs_old;
   logic [PHYS_W-1:0] w_wbs_new;

   rseq_state_t       r_state;
   rseq_state_t       w_state_nxt;
   logic              r_out_valid;
   logic [PHYS_W-1:0] r_psrc1;
   logic [PHYS_W-1:0] r_psrc2;
   logic [PHYS_W-1:0] r_pdst;
   logic [1:0]        r_src_ena;
   logic              r_dst_ena;
   logic              r_commit_err;

   assign w_wbs_new = rn_wbs[PHYS_W-1:0];
   assign w_wbs_old = rn_wbs[2*PHYS_W-1:PHYS_W];

   // Handshake uses the registered rn_full only, keeping the path free of renamer stall logic.
   assign w_slot_free = ~r_out_valid | out_ready;
   assign w_pop       = commit_valid & ~w_q_empty;
   assign in_ready    = w_slot_free & (~w_q_full | w_pop) & ~(in_dst_ena & rn_full);
   assign w_accept    = in_valid & in_ready;

   assign rn_read1     = in_src1;
   assign rn_read2     = in_src2;
   assign rn_read_ena  = w_accept ? in_src_ena : 2'b00;
   assign rn_write     = in_dst;
   assign rn_write_ena = w_accept & in_dst_ena;
   assign rn_ena       = w_accept & in_dst_ena;

   // Non-dest ops still occupy a slot so commits stay aligned with the queue.
   assign w_push_entry  = '{has_dst: in_dst_ena, old: RN_PHYS_W'(w_wbs_old)};
   assign rn_retire     = PHYS_W'(w_head.old);
   assign rn_retire_ena = w_pop & w_head.has_dst;

   rename_commit_fifo #(
      .DEPTH (QDEPTH)
   ) u_commit_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_accept),
      .i_data    (w_push_entry),
      .i_pop     (w_pop),
      .o_head_c  (w_head),
      .o_full_c  (w_q_full),
      .o_empty_c (w_q_empty)
   );

   // Dispatch register: sources see the pre-write mapping the renamer returns this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_psrc1     <= '0;
         r_psrc2     <= '0;
         r_pdst      <= '0;
         r_src_ena   <= 2'b00;
         r_dst_ena   <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_psrc1     <= in_src_ena[0] ? rn_read1_phys : '0;
         r_psrc2     <= in_src_ena[1] ? rn_read2_phys : '0;
         r_pdst      <= in_dst_ena ? w_wbs_new : '0;
         r_src_ena   <= in_src_ena;
         r_dst_ena   <= in_dst_ena;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_commit_err <= 1'b0;
      end else begin
         r_commit_err <= commit_valid & w_q_empty;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_psrc1   = r_psrc1;
   assign out_psrc2   = r_psrc2;
   assign out_pdst    = r_pdst;
   assign out_src_ena = r_src_ena;
   assign out_dst_ena = r_dst_ena;
   assign commit_err  = r_commit_err;

   // Observational FSM; it reports why the front end is stalled and gates nothing.
   assign w_free_stall = in_valid & in_dst_ena & rn_full;
   assign w_q_stall    = in_valid & w_q_full & ~w_pop;
   assign w_out_stall  = r_out_valid & ~out_ready & in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         FREE_STALL: begin
            if (!rn_full) begin
               w_state_nxt = RUN;
            end
         end
         Q_STALL: begin
            if (w_pop) begin
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt = rseq_stall_cause(w_free_stall, w_q_stall, w_out_stall);
         end
      endcase
   end

   assign state_o = 2'(r_state);

endmodule

// File: tb/tb_rename_sequencer.sv
// Bench for rename_sequencer: a behavioural renamer is attached and every cycle is checked
// against a queue-based reference model of the sequencing rules.
module tb_rename_sequencer;

   localparam int AW    = 4;
   localparam int PW    = 4;
   localparam int QD    = 8;
   localparam int NLIVE = 8;
   localparam int NFREE = 8;
   localparam int S_RUN  = 0;
   localparam int S_FREE = 1;
   localparam int S_Q    = 2;
   localparam int S_OUT  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_src1;
   logic [AW-1:0] in_src2;
   logic [1:0]    in_src_ena;
   logic [AW-1:0] in_dst;
   logic          in_dst_ena;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_psrc1;
   logic [PW-1:0] out_psrc2;
   logic [PW-1:0] out_pdst;
   logic [1:0]    out_src_ena;
   logic          out_dst_ena;
   logic          commit_valid;
   logic          commit_err;
   logic [1:0]    state_o;
   logic [AW-1:0] rn_read1;
   logic [AW-1:0] rn_read2;
   logic [1:0]    rn_read_ena;
   logic [AW-1:0] rn_write;
   logic          rn_write_ena;
   logic          rn_ena;
   logic [PW-1:0] rn_retire;
   logic          rn_retire_ena;
   logic [PW-1:0] rn_read1_phys;
   logic [PW-1:0] rn_read2_phys;
   logic [2*PW-1:0] rn_wbs;
   logic          rn_full;

   rename_sequencer #(
      .ARCH_W (AW),
      .PHYS_W (PW),
      .QDEPTH (QD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_src1       (in_src1),
      .in_src2       (in_src2),
      .in_src_ena    (in_src_ena),
      .in_dst        (in_dst),
      .in_dst_ena    (in_dst_ena),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_psrc1     (out_psrc1),
      .out_psrc2     (out_psrc2),
      .out_pdst      (out_pdst),
      .out_src_ena   (out_src_ena),
      .out_dst_ena   (out_dst_ena),
      .commit_valid  (commit_valid),
      .commit_err    (commit_err),
      .state_o       (state_o),
      .rn_read1      (rn_read1),
      .rn_read2      (rn_read2),
      .rn_read_ena   (rn_read_ena),
      .rn_write      (rn_write),
      .rn_write_ena  (rn_write_ena),
      .rn_ena        (rn_ena),
      .rn_retire     (rn_retire),
      .rn_retire_ena (rn_retire_ena),
      .rn_read1_phys (rn_read1_phys),
      .rn_read2_phys (rn_read2_phys),
      .rn_wbs        (rn_wbs),
      .rn_full       (rn_full)
   );

   always #5 clk = ~clk;

   // Renamer: arch 0..7 start identity-mapped, phys 8..15 start in a circular free list.
   // A retire of phys 0 is dropped (phys 0 stays pinned).
   logic [PW-1:0] rn_map [16];
   logic [PW-1:0] rn_fl  [NFREE];
   logic [2:0]    rn_fl_head;
   logic [2:0]    rn_fl_tail;
   logic [3:0]    rn_fl_cnt;
   logic          rn_alloc;
   logic          rn_ret;

   assign rn_read1_phys = rn_map[rn_read1];
   assign rn_read2_phys = rn_map[rn_read2];
   assign rn_wbs        = {rn_map[rn_write], rn_fl[rn_fl_head]};
   assign rn_full       = (rn_fl_cnt == 4'd0);
   assign rn_fl_tail    = rn_fl_head + rn_fl_cnt[2:0];
   assign rn_alloc      = rn_ena & rn_write_ena & (rn_fl_cnt != 4'd0);
   assign rn_ret        = rn_retire_ena & (rn_retire != '0);

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) rn_map[i] <= (i < NLIVE) ? PW'(i) : '0;
         for (int i = 0; i < NFREE; i++) rn_fl[i] <= PW'(NLIVE + i);
         rn_fl_head <= 3'd0;
         rn_fl_cnt  <= 4'd8;
      end else begin
         if (rn_alloc) begin
            rn_map[rn_write] <= rn_fl[rn_fl_head];
            rn_fl_head       <= rn_fl_head + 3'd1;
         end
         if (rn_ret) rn_fl[rn_fl_tail] <= rn_retire;
         rn_fl_cnt <= rn_fl_cnt + {3'b000, rn_ret} - {3'b000, rn_alloc};
      end
   end

   // Reference model: architectural map, free pool and commit queue as plain arrays/queues.
   typedef struct {
      bit has_dst;
      int old;
   } ref_commit_t;

   int          ref_map [NLIVE];
   int          ref_free [$];
   ref_commit_t ref_cq [$];
   bit          ref_out_valid;
   int          ref_psrc1;
   int          ref_psrc2;
   int          ref_pdst;
   bit [1:0]    ref_sena;
   bit          ref_dena;
   bit          ref_err;
   int          ref_state;

   int   n_checks;
   int   n_errors;
   logic last_in_ready;
   logic last_retire_ena;
   logic [PW-1:0] last_retire;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic ref_reset();
      for (int i = 0; i < NLIVE; i++) ref_map[i] = i;
      ref_free.delete();
      for (int i = 0; i < NFREE; i++) ref_free.push_back(NLIVE + i);
      ref_cq.delete();
      ref_out_valid = 1'b0;
      ref_psrc1 = 0;
      ref_psrc2 = 0;
      ref_pdst  = 0;
      ref_sena  = 2'b00;
      ref_dena  = 1'b0;
      ref_err   = 1'b0;
      ref_state = S_RUN;
   endtask

   task automatic drive_idle();
      in_valid     = 1'b0;
      in_src1      = '0;
      in_src2      = '0;
      in_src_ena   = 2'b00;
      in_dst       = '0;
      in_dst_ena   = 1'b0;
      out_ready    = 1'b1;
      commit_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive_idle();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ref_reset();
   endtask

   // One clock: check registered outputs, drive inputs, check combinational outputs, advance model.
   task automatic step(input bit v, input int s1, input int s2, input bit [1:0] sena,
                       input int d, input bit dena, input bit ordy, input bit cval);
      bit          rfull;
      bit          qfull;
      bit          pop;
      bit          exp_ready;
      bit          acc;
      bit          exp_ret;
      int          exp_ret_val;
      int          nxt;
      int          old_p;
      int          new_p;
      ref_commit_t head;

      check_eq("out_valid", 32'(out_valid), 32'(ref_out_valid));
      if (ref_out_valid) begin
         check_eq("out_psrc1", 32'(out_psrc1), 32'(ref_psrc1));
         check_eq("out_psrc2", 32'(out_psrc2), 32'(ref_psrc2));
         check_eq("out_pdst", 32'(out_pdst), 32'(ref_pdst));
         check_eq("out_src_ena", 32'(out_src_ena), 32'(ref_sena));
         check_eq("out_dst_ena", 32'(out_dst_ena), 32'(ref_dena));
      end
      check_eq("commit_err", 32'(commit_err), 32'(ref_err));
      check_eq("state", 32'(state_o), 32'(ref_state));

      in_valid     = v;
      in_src1      = AW'(s1);
      in_src2      = AW'(s2);
      in_src_ena   = sena;
      in_dst       = AW'(d);
      in_dst_ena   = dena;
      out_ready    = ordy;
      commit_valid = cval;
      #1;

      rfull     = (ref_free.size() == 0);
      qfull     = (ref_cq.size() == QD);
      pop       = cval && (ref_cq.size() != 0);
      exp_ready = (!ref_out_valid || ordy) && (!qfull || pop) && !(dena && rfull);
      acc       = v && exp_ready;
      exp_ret   = 1'b0;
      exp_ret_val = 0;
      if (pop) begin
         exp_ret     = ref_cq[0].has_dst;
         exp_ret_val = ref_cq[0].old;
      end

      check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
      check_eq("rn_retire_ena", 32'(rn_retire_ena), 32'(exp_ret));
      if (exp_ret) check_eq("rn_retire", 32'(rn_retire), 32'(exp_ret_val));
      check_eq("rn_ena", 32'(rn_ena), 32'(acc && dena));
      check_eq("rn_read_ena", 32'(rn_read_ena), 32'(acc ? sena : 2'b00));
      last_in_ready   = in_ready;
      last_retire_ena = rn_retire_ena;
      last_retire     = rn_retire;

      case (ref_state)
         S_FREE:  nxt = rfull ? S_FREE : S_RUN;
         S_Q:     nxt = pop ? S_RUN : S_Q;
         default: begin
            if (v && dena && rfull)             nxt = S_FREE;
            else if (v && qfull && !pop)        nxt = S_Q;
            else if (ref_out_valid && !ordy && v) nxt = S_OUT;
            else                                nxt = S_RUN;
         end
      endcase

      ref_err = cval && (ref_cq.size() == 0);
      old_p = ref_map[d];
      if (acc) begin
         new_p     = 0;
         ref_psrc1 = sena[0] ? ref_map[s1] : 0;
         ref_psrc2 = sena[1] ? ref_map[s2] : 0;
         if (dena) begin
            new_p      = ref_free.pop_front();
            ref_map[d] = new_p;
         end
         ref_pdst      = new_p;
         ref_sena      = sena;
         ref_dena      = dena;
         ref_out_valid = 1'b1;
      end else if (ordy) begin
         ref_out_valid = 1'b0;
      end
      if (pop) begin
         head = ref_cq.pop_front();
         if (head.has_dst && head.old != 0) ref_free.push_back(head.old);
      end
      if (acc) ref_cq.push_back('{has_dst: dena, old: old_p});
      ref_state = nxt;
      @(negedge clk);
   endtask

   task automatic idle(input bit cval);
      step(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b1, cval);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      apply_reset();

      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_pdst", 32'(out_pdst), 32'd0);
      check_eq("rst_out_psrc1", 32'(out_psrc1), 32'd0);
      check_eq("rst_commit_err", 32'(commit_err), 32'd0);
      check_eq("rst_state", 32'(state_o), 32'(S_RUN));
      check_eq("rst_rn_full", 32'(rn_full), 32'd0);
      idle(1'b0);

      // First op renames against the identity map and takes phys 8.
      step(1'b1, 3, 5, 2'b11, 2, 1'b1, 1'b1, 1'b0);
      check_eq("first_psrc1", 32'(out_psrc1), 32'd3);
      check_eq("first_psrc2", 32'(out_psrc2), 32'd5);
      check_eq("first_pdst", 32'(out_pdst), 32'd8);

      // Seven more dest ops drain the free list.
      for (int k = 0; k < 7; k++) step(1'b1, k, (k + 1) % 8, 2'b11, (k + 3) % 8, 1'b1, 1'b1, 1'b0);
      check_eq("free_list_empty", 32'(rn_full), 32'd1);
      step(1'b1, 1, 2, 2'b11, 4, 1'b1, 1'b1, 1'b0);
      check_eq("ninth_blocked", 32'(last_in_ready), 32'd0);
      check_eq("free_stall_state", 32'(state_o), 32'(S_FREE));

      // Commit of the first op retires phys 2; the freed register feeds the ninth op.
      step(1'b1, 1, 2, 2'b11, 4, 1'b1, 1'b1, 1'b1);
      check_eq("first_retire_ena", 32'(last_retire_ena), 32'd1);
      check_eq("first_retire", 32'(last_retire), 32'd2);
      step(1'b1, 1, 2, 2'b11, 4, 1'b1, 1'b1, 1'b0);
      check_eq("ninth_accept", 32'(last_in_ready), 32'd1);
      check_eq("ninth_pdst", 32'(out_pdst), 32'd2);
      idle(1'b0);

      // Non-dest ops fill the commit queue; a commit lets a push through the same cycle.
      apply_reset();
      for (int k = 0; k < QD; k++) step(1'b1, k, k, 2'b01, 0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1, 1, 2'b01, 0, 1'b0, 1'b1, 1'b0);
      check_eq("q_full_blocked", 32'(last_in_ready), 32'd0);
      check_eq("q_stall_state", 32'(state_o), 32'(S_Q));
      step(1'b1, 1, 1, 2'b01, 0, 1'b0, 1'b1, 1'b1);
      check_eq("q_full_pop_push", 32'(last_in_ready), 32'd1);
      check_eq("q_stall_exit", 32'(state_o), 32'(S_RUN));

      // Dispatch back-pressure holds the output op, release drains it and loads the next.
      apply_reset();
      step(1'b1, 1, 2, 2'b11, 3, 1'b1, 1'b1, 1'b0);
      step(1'b1, 3, 5, 2'b11, 5, 1'b1, 1'b0, 1'b0);
      check_eq("out_stall_blocked", 32'(last_in_ready), 32'd0);
      check_eq("out_stall_state", 32'(state_o), 32'(S_OUT));
      step(1'b1, 3, 5, 2'b11, 5, 1'b1, 1'b0, 1'b0);
      step(1'b1, 3, 5, 2'b11, 5, 1'b1, 1'b1, 1'b0);
      check_eq("out_release_accept", 32'(last_in_ready), 32'd1);
      check_eq("second_psrc1", 32'(out_psrc1), 32'd8);
      check_eq("second_psrc2_prewrite", 32'(out_psrc2), 32'd5);
      check_eq("second_pdst", 32'(out_pdst), 32'd9);
      idle(1'b0);

      // Commit with an empty queue pulses commit_err and retires nothing.
      apply_reset();
      idle(1'b1);
      check_eq("empty_commit_no_retire", 32'(last_retire_ena), 32'd0);
      check_eq("empty_commit_err", 32'(commit_err), 32'd1);
      idle(1'b0);
      check_eq("empty_commit_err_clears", 32'(commit_err), 32'd0);

      // Random traffic with a reset in the middle of the stream.
      for (int i = 0; i < 3000; i++) begin
         int cprob;
         if (i == 1500) begin
            apply_reset();
            check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
            check_eq("midrst_rn_full", 32'(rn_full), 32'd0);
         end
         cprob = ((i / 400) % 2 == 0) ? 3 : 7;
         step($urandom_range(0, 3) != 0,
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 9)) < cprob);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
